// File: rtl/apb_master.sv
// APB initiator: turns single-beat command requests into APB SETUP/ACCESS
// transfers and returns a one-cycle completion pulse with read data.
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS-phase wait to
// TIMEOUT_CYCLES cycles; an expired wait completes with rsp_err=1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer in flight; cmd_ready=1, APB fields hold last value
// SETUP  | first APB phase; psel=1, penable=0
// ACCESS | second APB phase; psel=1, penable=1, waiting for pready
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Reject an out-of-range wait bound at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          // A responder answering on the final allowed cycle still wins.
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    // cmd_ready is registered, so it is derived from where the FSM is going.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS wait counter and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: reset values, write/read timing, wait states,
// back-to-back throughput, reset abort, and the ACCESS wait bound.
module tb_apb_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef APB_TIMEOUT_EN
  localparam int RD_WAIT = 2;
`else
  localparam int RD_WAIT = 4;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  int total = 0;
  int bad   = 0;

  apb_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [10:0] exp_psel;
  logic [10:0] exp_rsp;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'hFFFF_FFFF;
    prdata    = 32'hCAFE_F00D;
    pready    = 1'b1;
    tick();
    tick();

    // Reset values
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_pwrite", {31'd0, pwrite}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_psel", {31'd0, psel}, 32'd0);

    // Write, zero wait states: accept N, SETUP N+1, ACCESS N+2, rsp N+3
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0010;
    cmd_wdata = 32'hDEAD_BEEF;
    pready    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'h5555_5555;
    cmd_wdata = 32'h0;
    check("wr_setup_psel", {31'd0, psel}, 32'd1);
    check("wr_setup_penable", {31'd0, penable}, 32'd0);
    check("wr_setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
    check("wr_setup_paddr", paddr, 32'h10);
    check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    tick();
    check("wr_access_psel", {31'd0, psel}, 32'd1);
    check("wr_access_penable", {31'd0, penable}, 32'd1);
    check("wr_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_rsp_psel", {31'd0, psel}, 32'd0);
    check("wr_rsp_penable", {31'd0, penable}, 32'd0);
    check("wr_rsp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("wr_idle_paddr_hold", paddr, 32'h10);
    tick();
    check("wr_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    check("wr_idle_pwdata_hold", pwdata, 32'hDEAD_BEEF);

    // Read with wait states; paddr stable, prdata captured on pready
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0020;
    cmd_wdata = 32'h0BAD_0BAD;
    pready    = 1'b0;
    prdata    = 32'hAAAA_5555;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'h7777_7777;
    check("rd_setup_paddr", paddr, 32'h20);
    check("rd_setup_pwrite", {31'd0, pwrite}, 32'd0);
    tick();
    for (int i = 0; i < RD_WAIT; i++) begin
      check("rd_wait_psel", {31'd0, psel}, 32'd1);
      check("rd_wait_penable", {31'd0, penable}, 32'd1);
      check("rd_wait_paddr", paddr, 32'h20);
      check("rd_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check("rd_last_access_penable", {31'd0, penable}, 32'd1);
    pready = 1'b1;
    prdata = 32'h1234_5678;
    tick();
    pready = 1'b0;
    prdata = 32'h0F0F_0F0F;
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rd_rsp_psel", {31'd0, psel}, 32'd0);
    tick();
    check("rd_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    check("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

    // Back-to-back writes with cmd_valid held high: 1 transfer per 3 cycles
    exp_psel  = 11'b00110110110;
    exp_rsp   = 11'b01001001000;
    pready    = 1'b1;
    cmd_write = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      cmd_valid = (c <= 6);
      cmd_addr  = 32'h100 + 32'(4 * (c / 3));
      cmd_wdata = 32'hA000_0000 + 32'(c / 3);
      check("b2b_psel", {31'd0, psel}, {31'd0, exp_psel[c]});
      check("b2b_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp[c]});
      if (c == 1 || c == 4 || c == 7) begin
        check("b2b_paddr", paddr, 32'h100 + 32'(4 * ((c - 1) / 3)));
        check("b2b_pwdata", pwdata, 32'hA000_0000 + 32'((c - 1) / 3));
      end
      tick();
    end
    cmd_valid = 1'b0;

    // Reset during ACCESS with pready low aborts silently
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h30;
    pready    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("abort_in_access", {31'd0, penable}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    pready = 1'b1;
    check("abort_psel", {31'd0, psel}, 32'd0);
    check("abort_penable", {31'd0, penable}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_paddr", paddr, 32'd0);
    tick();
    check("abort_no_rsp_1", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("abort_no_rsp_2", {31'd0, rsp_valid}, 32'd0);
    check("abort_still_idle", {31'd0, psel}, 32'd0);

`ifdef APB_TIMEOUT_EN
    // Timeout after 4 ACCESS cycles with pready stuck low
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    pready    = 1'b0;
    prdata    = 32'hDDDD_DDDD;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_penable", {31'd0, penable}, 32'd1);
      check("to_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    check("to_psel", {31'd0, psel}, 32'd0);
    check("to_penable", {31'd0, penable}, 32'd0);
    check("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    check("to_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    check("to_err_hold", {31'd0, rsp_err}, 32'd1);

    // pready arriving on the final allowed cycle completes normally
    cmd_valid = 1'b1;
    cmd_addr  = 32'h44;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("late_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    pready = 1'b1;
    prdata = 32'h8765_4321;
    tick();
    pready = 1'b0;
    check("late_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("late_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("late_rsp_rdata", rsp_rdata, 32'h8765_4321);
    tick();
`else
    // Without the wait bound, ACCESS persists while pready stays low
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    pready    = 1'b0;
    prdata    = 32'hDDDD_DDDD;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      check("hang_access", {30'd0, psel, penable}, 32'd3);
      check("hang_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    pready = 1'b1;
    prdata = 32'h8765_4321;
    tick();
    pready = 1'b0;
    check("hang_rsp_valid_end", {31'd0, rsp_valid}, 32'd1);
    check("hang_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("hang_rsp_rdata", rsp_rdata, 32'h8765_4321);
    tick();
`endif
    check("final_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, 32, APB address width in bits.
REQ-002 Parameter DATA_W, 32, APB data width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles; used only when APB_TIMEOUT_EN is defined; legal range 2..65535.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port cmd_valid  in  1  command request.
REQ-007 Port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on an edge.
REQ-008 Port cmd_write  in  1  1 = write, 0 = read.
REQ-009 Port cmd_addr  in  ADDR_W  transfer address.
REQ-010 Port cmd_wdata  in  DATA_W  write data.
REQ-011 Port rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 Port rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-013 Port rsp_err  out  1  timeout indication, qualified by rsp_valid.
REQ-014 Ports psel, penable, pwrite (out, 1 bit each); paddr (out, ADDR_W); pwdata (out, DATA_W): APB initiator outputs.
REQ-015 Ports prdata (in, DATA_W) and pready (in, 1): APB responder returns.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS; all outputs are registered.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 On accept in cycle N: cmd fields latched into pwrite/paddr/pwdata; state = SETUP in N+1 (psel=1, penable=0).
REQ-019 SETUP -> ACCESS unconditionally on the next cycle (psel=1, penable=1).
REQ-020 In ACCESS with pready=1: next state IDLE; psel=0, penable=0; rsp_valid=1 for exactly one cycle.
REQ-021 In ACCESS with pready=1 and pwrite=0: rsp_rdata = prdata sampled that cycle; for writes rsp_rdata = 0.
REQ-022 In ACCESS with pready=0: remain in ACCESS; all APB outputs held stable.
REQ-023 paddr, pwdata and pwrite SHALL NOT change between accept and return to IDLE; in IDLE they hold the last value.
REQ-024 Minimum transfer: accept N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
REQ-025 Back-to-back: cmd_ready=1 in the rsp_valid cycle; a command accepted at N+3 reaches SETUP at N+4, giving a sustained rate of 1 transfer per 3 cycles.
REQ-026 pready and prdata SHALL be ignored outside ACCESS.
REQ-027 rsp_rdata and rsp_err hold their values until the next rsp_valid.

Reset
REQ-028 reset=1 at an edge forces IDLE regardless of state, including mid-SETUP or mid-ACCESS; the aborted transfer produces no rsp_valid.
REQ-029 Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, cmd_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.

Configuration
REQ-030 With macro APB_TIMEOUT_EN defined: a counter clears on SETUP->ACCESS and increments for each ACCESS cycle with pready=0.
REQ-031 With APB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 with pready=0:
- go to IDLE;
- drop psel and penable;
- emit rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-032 With APB_TIMEOUT_EN defined, pready=1 on that same final cycle completes normally with rsp_err=0.
REQ-033 Without APB_TIMEOUT_EN: no counter is instantiated; ACCESS waits indefinitely; rsp_err is tied to 0.

Verification
REQ-034 Write addr=0x10, wdata=0xDEADBEEF, pready=1 immediately -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
REQ-035 Read addr=0x20, pready low 4 ACCESS cycles then high with prdata=0x12345678 -> paddr stable throughout; rsp_rdata=0x12345678 at 1 cycle after pready.
REQ-036 cmd_valid held high for 3 writes -> psel deasserts for exactly 1 cycle between transfers; 3 rsp_valid pulses spaced 3 cycles apart.
REQ-037 reset asserted during ACCESS with pready=0 -> next cycle psel=0, penable=0, cmd_ready=1; no rsp_valid.
REQ-038 APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready stuck 0 -> after 4 ACCESS cycles: rsp_valid=1, rsp_err=1, rsp_rdata=0, IDLE; without the macro the bench holds pready=0 for 100 cycles and ACCESS persists.
